// File: rtl/sweep_data_packer_pkg.sv
// ---------------------------------------------------------------------------
// sweep_data_packer_pkg
// Shared constants and types for the sweep data packer:
//   - frame marker words (header, trailer, end-of-sweep mark)
//   - default payload buffer geometry
//   - packer state enumeration
//   - sat16(): clamp an internal count to the 16-bit N field
// ---------------------------------------------------------------------------
package sweep_data_packer_pkg;

  localparam logic [15:0] HEADER_WORD  = 16'h5A5A;
  localparam logic [15:0] TRAILER_WORD = 16'hA5A5;
  localparam logic [15:0] END_WORD     = 16'hEEEE;

  localparam int DEFAULT_BUF_DEPTH = 256;
  localparam int DEFAULT_BUF_AW    = 8;

  // Internal word counters are wider than the N field so frame tracking
  // stays exact for frames longer than 0xFFFF words; only N saturates.
  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DACWORD,
    PAYLOAD,
    COUNT,
    TRAILER,
    DONE,
    ENDMARK
  } state_e;

  function automatic logic [15:0] sat16(input logic [CNT_W-1:0] v);
    return (|v[CNT_W-1:16]) ? 16'hFFFF : v[15:0];
  endfunction

endpackage

// File: rtl/sweep_data_packer_if.sv
// ---------------------------------------------------------------------------
// sweep_data_packer_if
// Bundles the acquisition-side inputs and USB-FIFO-side outputs of the
// sweep data packer.
//   master : the environment (acquisition stage + USB FIFO)
//   slave  : the packer itself
// Signals:
//   SweepACQData[15:0], SweepACQData_en  payload word + valid (no backpressure)
//   SingleDacDone, ACQDone               one-cycle step / sweep done pulses
//   OutDAC0[9:0]                         DAC0 value of the current step
//   UsbFifo_full                         downstream FIFO full
//   UsbFifoData[15:0], UsbFifoData_wren  word + write strobe to USB FIFO
//   DataTransmitDone                     pulse after a frame trailer
//   Overflow, StepError                  sticky error flags
// ---------------------------------------------------------------------------
interface sweep_data_packer_if;
  import sweep_data_packer_pkg::*;

  logic [15:0] SweepACQData;
  logic        SweepACQData_en;
  logic        SingleDacDone;
  logic        ACQDone;
  logic [9:0]  OutDAC0;
  logic        UsbFifo_full;
  logic [15:0] UsbFifoData;
  logic        UsbFifoData_wren;
  logic        DataTransmitDone;
  logic        Overflow;
  logic        StepError;

  modport master (
    output SweepACQData, SweepACQData_en, SingleDacDone, ACQDone, OutDAC0,
           UsbFifo_full,
    input  UsbFifoData, UsbFifoData_wren, DataTransmitDone, Overflow, StepError
  );

  modport slave (
    input  SweepACQData, SweepACQData_en, SingleDacDone, ACQDone, OutDAC0,
           UsbFifo_full,
    output UsbFifoData, UsbFifoData_wren, DataTransmitDone, Overflow, StepError
  );

endinterface

// File: rtl/sweep_pack_fifo.sv
// ---------------------------------------------------------------------------
// sweep_pack_fifo
// Synchronous show-ahead FIFO holding payload words between the acquisition
// stage and the frame writer. rd_data_o shows the head word whenever
// empty_o is low; rd_en_i pops it.
// Ports:
//   Clk, reset            clock, asynchronous active-high reset
//   wr_en_i, wr_data_i    push (ignored while full_o)
//   rd_en_i, rd_data_o    pop (ignored while empty_o), head word
//   full_o, empty_o       occupancy flags
// ---------------------------------------------------------------------------
module sweep_pack_fifo
  import sweep_data_packer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_BUF_DEPTH,
  parameter int AW    = DEFAULT_BUF_AW
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [15:0] wr_data_i,
  input  logic        rd_en_i,
  output logic [15:0] rd_data_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [15:0]   rd_data_q;

  logic          do_wr, do_rd;
  logic [AW-1:0] wr_ptr_inc, rd_ptr_inc, rd_addr;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;

  assign wr_ptr_inc = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + AW'(1);
  assign rd_ptr_inc = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + AW'(1);

  // Address of the word that will be at the head next cycle.
  assign rd_addr = do_rd ? rd_ptr_inc : rd_ptr_q;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_inc;
      if (do_rd) rd_ptr_q <= rd_ptr_inc;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // RAM array with registered read; kept free of reset so it maps onto
  // block RAM. The head register reloads every cycle, and a word written
  // into the slot about to become the head is forwarded directly, which
  // gives show-ahead behaviour one cycle after the first write.
  always_ff @(posedge Clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data_i;
    if (do_wr && (wr_ptr_q == rd_addr)) rd_data_q <= wr_data_i;
    else                                rd_data_q <= mem[rd_addr];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sweep_data_packer.sv
// ---------------------------------------------------------------------------
// sweep_data_packer
// Packs sweep acquisition data into USB frames, one per DAC step:
//   0x5A5A, {6'b0, DAC}, N payload words, N, 0xA5A5
// and emits a single 0xEEEE once the whole sweep is done.
// Ports:
//   Clk    single rising-edge clock
//   reset  asynchronous active-high reset
//   bus    sweep_data_packer_if.slave (see interface file for signals)
// ---------------------------------------------------------------------------
module sweep_data_packer
  import sweep_data_packer_pkg::*;
#(
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
  parameter int BUF_AW    = DEFAULT_BUF_AW
) (
  input logic                Clk,
  input logic                reset,
  sweep_data_packer_if.slave bus
);

  state_e           state_q;
  logic [9:0]       dac_q;
  logic [CNT_W-1:0] in_cnt_q;     // words accepted for the still-open frame
  logic [CNT_W-1:0] frame_len_q;  // frozen length of the closed frame
  logic [CNT_W-1:0] out_cnt_q;    // payload words written for current frame
  logic             done_pend_q;
  logic             acq_pend_q;
  logic             overflow_q;
  logic             step_err_q;

  logic             fifo_full, fifo_empty, fifo_rd;
  logic [15:0]      fifo_rd_data;

  logic             acc_word, done_take, frame_left, pay_wr;
  logic             wr_req, wren;
  logic [15:0]      out_word;

  assign acc_word = bus.SweepACQData_en && !fifo_full;

  // A step-done is accepted when none is pending, or in DONE where the
  // pending one is being retired that same cycle.
  assign done_take = bus.SingleDacDone && (!done_pend_q || (state_q == DONE));

  // Until the frame is closed every buffered word belongs to it; once
  // closed, only frame_len_q words do and the rest belong to the next one.
  assign frame_left = done_pend_q ? (out_cnt_q != frame_len_q) : 1'b1;
  assign pay_wr     = (state_q == PAYLOAD) && frame_left && !fifo_empty;
  assign fifo_rd    = pay_wr && !bus.UsbFifo_full;

  sweep_pack_fifo #(
    .DEPTH (BUF_DEPTH),
    .AW    (BUF_AW)
  ) u_fifo (
    .Clk       (Clk),
    .reset     (reset),
    .wr_en_i   (bus.SweepACQData_en),
    .wr_data_i (bus.SweepACQData),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Output word and write request decoded from the registered state. The
  // strobe is gated by the live full flag so it can never be high while
  // the USB FIFO is full.
  always_comb begin
    wr_req   = 1'b0;
    out_word = 16'h0000;
    case (state_q)
      HEADER:  begin wr_req = 1'b1;   out_word = HEADER_WORD;       end
      DACWORD: begin wr_req = 1'b1;   out_word = {6'b0, dac_q};     end
      PAYLOAD: begin wr_req = pay_wr; out_word = fifo_rd_data;      end
      COUNT:   begin wr_req = 1'b1;   out_word = sat16(out_cnt_q);  end
      TRAILER: begin wr_req = 1'b1;   out_word = TRAILER_WORD;      end
      ENDMARK: begin wr_req = 1'b1;   out_word = END_WORD;          end
      default: ;
    endcase
  end

  assign wren = wr_req && !bus.UsbFifo_full;

  assign bus.UsbFifoData      = out_word;
  assign bus.UsbFifoData_wren = wren;
  assign bus.DataTransmitDone = (state_q == DONE);
  assign bus.Overflow         = overflow_q;
  assign bus.StepError        = step_err_q;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dac_q       <= '0;
      in_cnt_q    <= '0;
      frame_len_q <= '0;
      out_cnt_q   <= '0;
      done_pend_q <= 1'b0;
      acq_pend_q  <= 1'b0;
      overflow_q  <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      if (bus.SweepACQData_en && fifo_full) overflow_q <= 1'b1;
      if (bus.SingleDacDone && !done_take)  step_err_q <= 1'b1;

      // Closing a frame includes a word accepted on the same cycle.
      if (done_take) begin
        frame_len_q <= in_cnt_q + CNT_W'(acc_word);
        in_cnt_q    <= '0;
      end else if (acc_word) begin
        in_cnt_q    <= in_cnt_q + CNT_W'(1);
      end

      if (done_take)             done_pend_q <= 1'b1;
      else if (state_q == DONE)  done_pend_q <= 1'b0;

      if (bus.ACQDone)                                   acq_pend_q <= 1'b1;
      else if ((state_q == ENDMARK) && !bus.UsbFifo_full) acq_pend_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // Pending frames always go out before the end-of-sweep mark.
          if (done_pend_q || !fifo_empty) begin
            state_q   <= HEADER;
            dac_q     <= bus.OutDAC0;
            out_cnt_q <= '0;
          end else if (acq_pend_q) begin
            state_q   <= ENDMARK;
          end
        end
        HEADER:  if (!bus.UsbFifo_full) state_q <= DACWORD;
        DACWORD: if (!bus.UsbFifo_full) state_q <= PAYLOAD;
        PAYLOAD: begin
          if (done_pend_q && (out_cnt_q == frame_len_q)) begin
            state_q <= COUNT;
          end else if (fifo_rd) begin
            out_cnt_q <= out_cnt_q + CNT_W'(1);
          end
        end
        COUNT:   if (!bus.UsbFifo_full) state_q <= TRAILER;
        TRAILER: if (!bus.UsbFifo_full) state_q <= DONE;
        DONE:    state_q <= IDLE;
        ENDMARK: if (!bus.UsbFifo_full) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_data_packer.sv
// ---------------------------------------------------------------------------
// tb_sweep_data_packer
// Directed bench for sweep_data_packer. Expected USB words are queued as the
// stimulus is issued; a negedge monitor pops and compares each written word.
// ---------------------------------------------------------------------------
module tb_sweep_data_packer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sweep_data_packer_if bus();

  sweep_data_packer #(
    .BUF_DEPTH (256),
    .BUF_AW    (8)
  ) dut (
    .Clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [15:0] exp_q[$];
  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  bit          tgl_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: one line per written word, compared against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.DataTransmitDone === 1'b1) done_cnt++;
      if (bus.UsbFifoData_wren !== 1'b0) begin
        chk("wren_while_full", 32'(bus.UsbFifo_full), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_word: observed=%h expected=none", bus.UsbFifoData);
          end
        end else begin
          $display("word %h (expected %h)", bus.UsbFifoData, exp_q[0]);
          chk("stream_word", 32'(bus.UsbFifoData), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (tgl_en) bus.UsbFifo_full = ~bus.UsbFifo_full;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.SweepACQData    = base + 16'(i);
      bus.SweepACQData_en = 1'b1;
      cyc();
    end
    bus.SweepACQData_en = 1'b0;
  endtask

  task automatic pulse_done();
    bus.SingleDacDone = 1'b1;
    cyc();
    bus.SingleDacDone = 1'b0;
  endtask

  task automatic push_frame(input logic [9:0] dac, input logic [15:0] base, input int n);
    exp_q.push_back(16'h5A5A);
    exp_q.push_back({6'b0, dac});
    for (int i = 0; i < n; i++) exp_q.push_back(base + 16'(i));
    exp_q.push_back(16'(n));
    exp_q.push_back(16'hA5A5);
  endtask

  task automatic drain(input string tag, input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      cyc();
      k++;
    end
    chk({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    idle(4);
  endtask

  initial begin
    reset               = 1'b1;
    bus.SweepACQData    = '0;
    bus.SweepACQData_en = 1'b0;
    bus.SingleDacDone   = 1'b0;
    bus.ACQDone         = 1'b0;
    bus.OutDAC0         = '0;
    bus.UsbFifo_full    = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  32'(bus.UsbFifoData), 32'h0);
    chk("rst_wren",  32'(bus.UsbFifoData_wren), 32'h0);
    chk("rst_dtd",   32'(bus.DataTransmitDone), 32'h0);
    chk("rst_ovf",   32'(bus.Overflow), 32'h0);
    chk("rst_steperr", 32'(bus.StepError), 32'h0);
    reset = 1'b0;
    idle(2);

    // Basic 3-word frame
    bus.OutDAC0 = 10'h155;
    push_frame(10'h155, 16'h0001, 3);
    send_words(16'h0001, 3);
    pulse_done();
    drain("basic", 50);
    chk("dtd_basic", done_cnt, 1);

    // Empty frame
    bus.OutDAC0 = 10'h3FF;
    push_frame(10'h3FF, 16'h0000, 0);
    pulse_done();
    drain("empty", 50);
    chk("dtd_empty", done_cnt, 2);
    chk("steperr_clear", 32'(bus.StepError), 32'h0);

    // USB FIFO full every other cycle during a 10-word frame
    bus.OutDAC0 = 10'h0A5;
    push_frame(10'h0A5, 16'h0100, 10);
    tgl_en = 1'b1;
    send_words(16'h0100, 10);
    pulse_done();
    drain("toggle", 200);
    tgl_en = 1'b0;
    bus.UsbFifo_full = 1'b0;
    chk("dtd_toggle", done_cnt, 3);

    // Word coincident with step-done closes the first frame
    bus.OutDAC0 = 10'h111;
    push_frame(10'h111, 16'h0201, 3);
    push_frame(10'h222, 16'h0204, 2);
    send_words(16'h0201, 2);
    bus.SweepACQData    = 16'h0203;
    bus.SweepACQData_en = 1'b1;
    bus.SingleDacDone   = 1'b1;
    cyc();
    bus.SweepACQData_en = 1'b0;
    bus.SingleDacDone   = 1'b0;
    bus.OutDAC0         = 10'h222;
    send_words(16'h0204, 2);
    idle(20);
    pulse_done();
    drain("coincident", 100);
    chk("dtd_coincident", done_cnt, 5);
    chk("steperr_still_clear", 32'(bus.StepError), 32'h0);

    // Second step-done while one is pending is ignored and flagged
    bus.OutDAC0 = 10'h2AA;
    push_frame(10'h2AA, 16'h0000, 0);
    bus.SingleDacDone = 1'b1;
    cyc();
    cyc();
    bus.SingleDacDone = 1'b0;
    drain("double_done", 50);
    chk("steperr_set", 32'(bus.StepError), 32'h1);
    chk("dtd_double_done", done_cnt, 6);

    // Overflow: 256 words fill the buffer while USB FIFO is full, 2 dropped
    chk("ovf_clear", 32'(bus.Overflow), 32'h0);
    bus.UsbFifo_full = 1'b1;
    bus.OutDAC0      = 10'h0F0;
    push_frame(10'h0F0, 16'h1000, 256);
    send_words(16'h1000, 256);
    send_words(16'hDEAD, 2);
    idle(2);
    chk("ovf_set", 32'(bus.Overflow), 32'h1);
    pulse_done();
    bus.UsbFifo_full = 1'b0;
    drain("overflow", 1000);
    chk("dtd_overflow", done_cnt, 7);

    // End-of-sweep mark after the last frame, exactly once
    exp_q.push_back(16'hEEEE);
    bus.ACQDone = 1'b1;
    cyc();
    bus.ACQDone = 1'b0;
    drain("endmark", 20);
    idle(10);
    chk("dtd_endmark", done_cnt, 7);

    // New run, reset mid-frame: no trailer or done afterwards
    bus.OutDAC0 = 10'h033;
    exp_q.push_back(16'h5A5A);
    exp_q.push_back(16'h0033);
    exp_q.push_back(16'h0301);
    exp_q.push_back(16'h0302);
    send_words(16'h0301, 2);
    drain("midframe", 30);
    reset = 1'b1;
    #2;
    chk("mid_rst_data",  32'(bus.UsbFifoData), 32'h0);
    chk("mid_rst_wren",  32'(bus.UsbFifoData_wren), 32'h0);
    chk("mid_rst_dtd",   32'(bus.DataTransmitDone), 32'h0);
    chk("mid_rst_ovf",   32'(bus.Overflow), 32'h0);
    chk("mid_rst_steperr", 32'(bus.StepError), 32'h0);
    idle(3);
    reset = 1'b0;
    idle(20);
    chk("dtd_after_reset", done_cnt, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
